// File: rtl/sram_port_arbiter_pkg.sv
// Shared owner encodings, lock-FSM states and the request-field bundle for the SRAM port arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sram_port_arbiter_pkg;

    // Owner tag stored per accepted transaction; one bit distinguishes the two requesters.
    localparam logic OWNER_INST = 1'b0;
    localparam logic OWNER_DATA = 1'b1;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_LOCK_I = 2'd1,
        ARB_LOCK_D = 2'd2
    } arb_state_t;

    // Everything that travels alongside a request and must be muxed as a unit.
    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
    } sram_cmd_t;

    function automatic arb_state_t lock_state(input logic owner);
        return (owner == OWNER_DATA) ? ARB_LOCK_D : ARB_LOCK_I;
    endfunction

endpackage

// File: rtl/arb_owner_fifo.sv
// In-order FIFO of 1-bit owner tags, one entry per accepted-but-unanswered transaction.
// Latency: push visible at head one cycle later; head/full/empty are registered-state decodes.
// Backpressure: push ignored when full, pop ignored when empty; count saturates in both directions.
//
// Ports: clk, reset (sync, active-high); push + push_owner write a tag; pop retires the head;
//        head is the oldest tag; full/empty flag the occupancy.
module arb_owner_fifo #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  logic push_owner,
    input  logic pop,
    output logic head,
    output logic full,
    output logic empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DEPTH-1:0] owner_q;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = owner_q[rd_ptr];

    // Tag storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            owner_q[wr_ptr] <= push_owner;
        end
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one SRAM-like port between the inst (IF) and data (EX/MEM) requesters; responses return in order.
// Latency: zero-cycle combinational address handshake and data_ok/rdata routing; owner tag lands in the FIFO next cycle.
// Backpressure: grant locks until mem_addr_ok; mem_req drops while MAX_OUTST transactions are outstanding.
//
// Ports: clk, reset (sync, active-high); inst_* and data_* requester ports (req, wr, size, wstrb,
//        addr, wdata in; addr_ok, data_ok, rdata out); mem_* shared port towards the bus bridge.
// Build option: define SRAM_ARB_RR_EN for round-robin idle arbitration; otherwise data has fixed priority.
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int MAX_OUTST = 4,
    parameter int CNT_W     = 3
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);

    arb_state_t state_q;
    arb_state_t state_d;
    logic       idle_grant;
    logic       grant;
    logic       accept;
    logic       fifo_full;
    logic       fifo_empty;
    logic       fifo_head;
    sram_cmd_t  inst_cmd;
    sram_cmd_t  data_cmd;
    sram_cmd_t  mem_cmd;

    assign inst_cmd = '{wr: inst_wr, size: inst_size, wstrb: inst_wstrb,
                        addr: inst_addr, wdata: inst_wdata};
    assign data_cmd = '{wr: data_wr, size: data_size, wstrb: data_wstrb,
                        addr: data_addr, wdata: data_wdata};

    // ------------------------------------------------------------------
    // Idle arbitration
    // ------------------------------------------------------------------
`ifdef SRAM_ARB_RR_EN
    logic rr_last_q;

    // With one-bit owner encoding, "the side not served last" is just ~rr_last.
    always_comb begin
        idle_grant = data_req ? OWNER_DATA : OWNER_INST;
        if (inst_req && data_req) begin
            idle_grant = ~rr_last_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_last_q <= OWNER_INST;
        end else if (accept) begin
            rr_last_q <= grant;
        end
    end
`else
    assign idle_grant = data_req ? OWNER_DATA : OWNER_INST;
`endif

    // ------------------------------------------------------------------
    // Lock FSM: once a request is presented but not yet accepted, the mem_*
    // fields must not change, so the grant is pinned until mem_addr_ok.
    // A lock can only start while mem_req is high, i.e. while not full, and
    // occupancy cannot rise while locked, so full never coincides with a lock.
    // ------------------------------------------------------------------
    assign mem_req = (inst_req | data_req) & ~fifo_full;
    assign accept  = mem_req & mem_addr_ok;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant   = idle_grant;
        case (state_q)
            ARB_IDLE: begin
                if (mem_req && !mem_addr_ok) begin
                    state_d = lock_state(idle_grant);
                end
            end
            ARB_LOCK_I: begin
                grant = OWNER_INST;
                if (accept) begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_LOCK_D: begin
                grant = OWNER_DATA;
                if (accept) begin
                    state_d = ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request mux and address handshake
    // ------------------------------------------------------------------
    assign mem_cmd   = (grant == OWNER_DATA) ? data_cmd : inst_cmd;
    assign mem_wr    = mem_cmd.wr;
    assign mem_size  = mem_cmd.size;
    assign mem_wstrb = mem_cmd.wstrb;
    assign mem_addr  = mem_cmd.addr;
    assign mem_wdata = mem_cmd.wdata;

    assign inst_addr_ok = accept & (grant == OWNER_INST);
    assign data_addr_ok = accept & (grant == OWNER_DATA);

    // ------------------------------------------------------------------
    // Owner tracking and response demux
    // ------------------------------------------------------------------
    arb_owner_fifo #(
        .DEPTH (MAX_OUTST),
        .CNT_W (CNT_W)
    ) u_owner_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (accept),
        .push_owner (grant),
        .pop        (mem_data_ok),
        .head       (fifo_head),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    // A response with nothing outstanding is dropped rather than routed.
    assign inst_data_ok = mem_data_ok & ~fifo_empty & (fifo_head == OWNER_INST);
    assign data_data_ok = mem_data_ok & ~fifo_empty & (fifo_head == OWNER_DATA);

    // Requesters qualify rdata with their own data_ok, so it is shared unregistered.
    assign inst_rdata = mem_rdata;
    assign data_rdata = mem_rdata;

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(mem_data_ok && fifo_empty))
                else $warning("sram_port_arbiter: mem_data_ok with no outstanding transaction");
        end
    end

endmodule
